mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 111 +++++++++++
 tb/tb_mem_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory responder with fixed access latency. It serves one load or store at
// a time and holds ready low so the pipeline stalls until the access completes.
module mem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 3,
    parameter int BASE_ADDR   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [3:0]        counter;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic              lat_write;
    logic              req;
    logic [31:0]       offset;
    logic [IDX_W-1:0]  index;
    logic [31:0]       mem [DEPTH];

    assign req = mem_r_en | mem_w_en;

    // Wrap-around subtraction lets addresses below the base fold back to the top words
    assign offset = lat_addr - 32'(BASE_ADDR);
    assign index  = IDX_W'((offset >> 2) % 32'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = BUSY;
                end else begin
                    ready = 1'b1;
                end
            end
            BUSY: begin
                if (counter == 4'd0) begin
                    next_state = BUSY == state ? DONE : state;
                end
            end
            DONE: begin
                ready      = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The access itself commits on the last BUSY cycle, so reset in BUSY drops it
    always_ff @(posedge clk) begin
        if (rst) begin
            counter   <= 4'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_write <= 1'b0;
            rdata     <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_addr  <= address;
                        lat_wdata <= wdata;
                        lat_write <= mem_w_en;
                        counter   <= 4'(WAIT_CYCLES - 1);
                    end
                end
                BUSY: begin
                    if (counter != 4'd0) begin
                        counter <= counter - 4'd1;
                    end else if (lat_write) begin
                        mem[index] <= lat_wdata;
                    end else begin
                        rdata <= mem[index];
                    end
                end
                DONE: begin
                    rdata <= 32'd0;
                end
                default: begin
                    rdata <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a default-latency instance and a
// single-wait-cycle instance driven from one linear initial block.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    logic        r1_en;
    logic        w1_en;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic [31:0] rdata1;
    logic        ready1;

    int total;
    int bad;

    mem_responder #(.DEPTH(64), .WAIT_CYCLES(3), .BASE_ADDR(1024)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_r_en (mem_r_en),
        .mem_w_en (mem_w_en),
        .address  (address),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready)
    );

    mem_responder #(.DEPTH(64), .WAIT_CYCLES(1), .BASE_ADDR(1024)) dut_w1 (
        .clk      (clk),
        .rst      (rst),
        .mem_r_en (r1_en),
        .mem_w_en (w1_en),
        .address  (addr1),
        .wdata    (wdata1),
        .rdata    (rdata1),
        .ready    (ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic driveMain(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d);
        mem_r_en = r;
        mem_w_en = w;
        address  = a;
        wdata    = d;
    endtask

    // One complete access on the WAIT_CYCLES=3 instance: request cycle, three
    // BUSY cycles, DONE, then one idle cycle. junk scrambles inputs during BUSY.
    task automatic applyStimulus(input string tag, input logic r, input logic w,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] exp_rdata, input bit junk);
        step();
        driveMain(r, w, a, d);
        #1;
        checkOutput({tag, ".req_ready"}, {31'd0, ready}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            if (junk) driveMain(1'b1, 1'b1, 32'd1028, 32'hFFFF_FFFF);
            else      driveMain(1'b0, 1'b0, 32'd0, 32'd0);
            #1;
            checkOutput($sformatf("%s.busy%0d_ready", tag, k), {31'd0, ready}, 32'd0);
        end
        step();
        driveMain(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        checkOutput({tag, ".done_ready"}, {31'd0, ready}, 32'd1);
        checkOutput({tag, ".done_rdata"}, rdata, exp_rdata);
        step();
        #1;
        checkOutput({tag, ".idle_ready"}, {31'd0, ready}, 32'd1);
        checkOutput({tag, ".idle_rdata"}, rdata, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        driveMain(1'b0, 1'b0, 32'd0, 32'd0);
        r1_en  = 1'b0;
        w1_en  = 1'b0;
        addr1  = 32'd0;
        wdata1 = 32'd0;
        step();
        step();
        rst = 1'b0;
        #1;
        checkOutput("reset.ready", {31'd0, ready}, 32'd1);
        checkOutput("reset.rdata", rdata, 32'd0);

        applyStimulus("wr_beef", 1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 32'd0, 1'b0);
        applyStimulus("rd_beef", 1'b1, 1'b0, 32'd1024, 32'd0, 32'hDEAD_BEEF, 1'b0);

        // 1024+256 lands on word 0 again; 1276 is word 63, reached from 1020 by wrap
        applyStimulus("wr_wrap", 1'b0, 1'b1, 32'd1280, 32'h0000_0011, 32'd0, 1'b0);
        applyStimulus("rd_wrap", 1'b1, 1'b0, 32'd1024, 32'd0, 32'h0000_0011, 1'b0);
        applyStimulus("wr_w63", 1'b0, 1'b1, 32'd1276, 32'hCAFE_0063, 32'd0, 1'b0);
        applyStimulus("rd_below", 1'b1, 1'b0, 32'd1020, 32'd0, 32'hCAFE_0063, 1'b0);

        applyStimulus("both_en", 1'b1, 1'b1, 32'd1028, 32'h0000_005A, 32'd0, 1'b0);
        applyStimulus("rd_both", 1'b1, 1'b0, 32'd1028, 32'd0, 32'h0000_005A, 1'b0);

        applyStimulus("rd_junk", 1'b1, 1'b0, 32'd1024, 32'd0, 32'h0000_0011, 1'b1);
        applyStimulus("rd_after_junk", 1'b1, 1'b0, 32'd1028, 32'd0, 32'h0000_005A, 1'b0);

        // Request held 12 cycles: DONE at offsets 4 and 9, third access ends at 14
        for (int i = 0; i < 15; i++) begin
            step();
            if (i < 12) driveMain(1'b1, 1'b0, 32'd1024, 32'd0);
            else        driveMain(1'b0, 1'b0, 32'd0, 32'd0);
            #1;
            checkOutput($sformatf("held.c%0d_ready", i), {31'd0, ready},
                        (i == 4 || i == 9 || i == 14) ? 32'd1 : 32'd0);
            checkOutput($sformatf("held.c%0d_rdata", i), rdata,
                        (i == 4 || i == 9 || i == 14) ? 32'h0000_0011 : 32'd0);
        end
        step();
        #1;
        checkOutput("held.idle_ready", {31'd0, ready}, 32'd1);

        // Reset during the second BUSY cycle of a write
        step();
        driveMain(1'b0, 1'b1, 32'd1032, 32'h0000_0077);
        #1;
        checkOutput("rstmid.req_ready", {31'd0, ready}, 32'd0);
        step();
        driveMain(1'b0, 1'b0, 32'd0, 32'd0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checkOutput("rstmid.ready", {31'd0, ready}, 32'd1);
        checkOutput("rstmid.rdata", rdata, 32'd0);
        applyStimulus("rd_after_rst", 1'b1, 1'b0, 32'd1032, 32'd0, 32'd0, 1'b0);
        applyStimulus("rd_cleared", 1'b1, 1'b0, 32'd1024, 32'd0, 32'd0, 1'b0);

        // WAIT_CYCLES=1 instance: write then read, ready exactly at T+2
        step();
        w1_en  = 1'b1;
        addr1  = 32'd1040;
        wdata1 = 32'h1234_5678;
        #1;
        checkOutput("w1.wr_t0_ready", {31'd0, ready1}, 32'd0);
        step();
        w1_en  = 1'b0;
        addr1  = 32'd0;
        wdata1 = 32'd0;
        #1;
        checkOutput("w1.wr_t1_ready", {31'd0, ready1}, 32'd0);
        step();
        #1;
        checkOutput("w1.wr_t2_ready", {31'd0, ready1}, 32'd1);
        step();
        r1_en = 1'b1;
        addr1 = 32'd1040;
        #1;
        checkOutput("w1.rd_t0_ready", {31'd0, ready1}, 32'd0);
        step();
        r1_en = 1'b0;
        addr1 = 32'd0;
        #1;
        checkOutput("w1.rd_t1_ready", {31'd0, ready1}, 32'd0);
        checkOutput("w1.rd_t1_rdata", rdata1, 32'd0);
        step();
        #1;
        checkOutput("w1.rd_t2_ready", {31'd0, ready1}, 32'd1);
        checkOutput("w1.rd_t2_rdata", rdata1, 32'h1234_5678);
        step();
        #1;
        checkOutput("w1.idle_ready", {31'd0, ready1}, 32'd1);
        checkOutput("w1.idle_rdata", rdata1, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
